// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_pkg
// Brief  : ALU opcode/class encodings, FSM state type and shared constants.
// Rev    : 1.0
// ============================================================================
package ex_pkg;

  localparam int c_xlen_max = 64;
  localparam logic [c_xlen_max-1:0] c_zero_word = '0;

  localparam logic [7:0] c_aluop_or   = 8'b0010_0101;
  localparam logic [7:0] c_aluop_and  = 8'b0010_0100;
  localparam logic [7:0] c_aluop_xor  = 8'b0010_0110;
  localparam logic [7:0] c_aluop_nor  = 8'b0010_0111;
  localparam logic [7:0] c_aluop_sll  = 8'b0111_1100;
  localparam logic [7:0] c_aluop_srl  = 8'b0000_0010;
  localparam logic [7:0] c_aluop_sra  = 8'b0000_0011;
  localparam logic [7:0] c_aluop_add  = 8'b0010_0000;
  localparam logic [7:0] c_aluop_sub  = 8'b0010_0010;
  localparam logic [7:0] c_aluop_slt  = 8'b0010_1010;
  localparam logic [7:0] c_aluop_sltu = 8'b0010_1011;
  localparam logic [7:0] c_aluop_mul  = 8'b1010_1001;

  localparam logic [2:0] c_alusel_nop   = 3'b000;
  localparam logic [2:0] c_alusel_logic = 3'b001;
  localparam logic [2:0] c_alusel_shift = 3'b010;
  localparam logic [2:0] c_alusel_arith = 3'b100;
  localparam logic [2:0] c_alusel_mul   = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } ex_state_e;

  // Result class an opcode belongs to; c_alusel_nop for anything unrecognised.
  function automatic logic [2:0] op_class(input logic [7:0] op);
    case (op)
      c_aluop_or, c_aluop_and, c_aluop_xor, c_aluop_nor: op_class = c_alusel_logic;
      c_aluop_sll, c_aluop_srl, c_aluop_sra:             op_class = c_alusel_shift;
      c_aluop_add, c_aluop_sub, c_aluop_slt, c_aluop_sltu: op_class = c_alusel_arith;
`ifdef EX_MUL_EN
      c_aluop_mul:                                       op_class = c_alusel_mul;
`endif
      default:                                           op_class = c_alusel_nop;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mc_if.sv
`default_nettype none
// ============================================================================
// Module : ex_mc_if
// Brief  : Operation request / result bundle between issue stage and ex_mc.
// Rev    : 1.0
// ============================================================================
interface ex_mc_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               valid_i;
  logic               flush_i;
  logic [7:0]         aluop_i;
  logic [2:0]         alusel_i;
  logic [XLEN-1:0]    reg1_i;
  logic [XLEN-1:0]    reg2_i;
  logic [RADDR_W-1:0] wd_i;
  logic               wreg_i;
  logic               valid_o;
  logic [RADDR_W-1:0] wd_o;
  logic               wreg_o;
  logic [XLEN-1:0]    wdata_o;
  logic               stallreq_o;

  modport master (
    output valid_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  valid_o, wd_o, wreg_o, wdata_o, stallreq_o
  );

  modport slave (
    input  valid_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output valid_o, wd_o, wreg_o, wdata_o, stallreq_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
// Module : ex_mul_iter
// Brief  : Iterative shift-add multiplier, one partial product per step.
// Rev    : 1.0
// ============================================================================
module ex_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic            o_hold,
  output logic [XLEN-1:0] o_product
);
  localparam int c_cnt_w = $clog2(XLEN) + 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic [XLEN-1:0]    r_acc;
  logic [XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic [XLEN-1:0]    w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // The product is taken from the final step's sum so it lands on the done edge.
  assign o_product  = w_acc_next;
  assign o_done     = i_step && (r_cnt == c_cnt_w'(XLEN - 1));
  assign o_hold     = r_cnt < c_cnt_w'(XLEN - 1);

  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (i_step) begin
      r_cnt    <= r_cnt + 1'b1;
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/ex_mc.sv
`default_nettype none
// ============================================================================
// Module : ex_mc
// Brief  : Execute stage: single-cycle logic/shift/arith, multi-cycle MUL.
//          Define EX_MUL_EN to build in the iterative multiplier.
// Rev    : 1.0
// ============================================================================
module ex_mc
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic    clk,
  input  logic    rst,
  ex_mc_if.slave  bus
);
  localparam int c_shamt_w = $clog2(XLEN);

  ex_state_e          r_state;
  ex_state_e          w_state_next;
  logic               r_valid, w_valid_next;
  logic               r_wreg, w_wreg_next;
  logic [RADDR_W-1:0] r_wd, w_wd_next;
  logic [XLEN-1:0]    r_wdata, w_wdata_next;
  logic [RADDR_W-1:0] r_mul_wd;
  logic               r_mul_wreg;
  logic               w_mul_start;
  logic               w_is_mul;
  logic               w_mul_done;
  logic               w_mul_hold;
  logic [XLEN-1:0]    w_mul_prod;
  logic [XLEN-1:0]    w_alu_res;
  logic [c_shamt_w-1:0] w_shamt;

  assign w_shamt = bus.reg2_i[c_shamt_w-1:0];

  // Unknown opcodes and class mismatches fall through to a zero result.
  always_comb begin
    w_alu_res = c_zero_word[XLEN-1:0];
    if (bus.alusel_i != c_alusel_nop && op_class(bus.aluop_i) == bus.alusel_i) begin
      case (bus.aluop_i)
        c_aluop_or:   w_alu_res = bus.reg1_i | bus.reg2_i;
        c_aluop_and:  w_alu_res = bus.reg1_i & bus.reg2_i;
        c_aluop_xor:  w_alu_res = bus.reg1_i ^ bus.reg2_i;
        c_aluop_nor:  w_alu_res = ~(bus.reg1_i | bus.reg2_i);
        c_aluop_sll:  w_alu_res = bus.reg1_i << w_shamt;
        c_aluop_srl:  w_alu_res = bus.reg1_i >> w_shamt;
        c_aluop_sra:  w_alu_res = $signed(bus.reg1_i) >>> w_shamt;
        c_aluop_add:  w_alu_res = bus.reg1_i + bus.reg2_i;
        c_aluop_sub:  w_alu_res = bus.reg1_i - bus.reg2_i;
        c_aluop_slt:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
        c_aluop_sltu: w_alu_res = {{(XLEN-1){1'b0}}, bus.reg1_i < bus.reg2_i};
        default:      w_alu_res = c_zero_word[XLEN-1:0];
      endcase
    end
  end

`ifdef EX_MUL_EN
  logic w_mul_step;

  assign w_is_mul   = (bus.aluop_i == c_aluop_mul) && (bus.alusel_i == c_alusel_mul);
  assign w_mul_step = (r_state == S_BUSY) && !bus.flush_i;

  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_abort   (bus.flush_i),
    .i_step    (w_mul_step),
    .i_a       (bus.reg1_i),
    .i_b       (bus.reg2_i),
    .o_done    (w_mul_done),
    .o_hold    (w_mul_hold),
    .o_product (w_mul_prod)
  );

  // Drops in the final BUSY cycle so upstream can line up the next op.
  assign bus.stallreq_o = !rst &&
      (((r_state == S_IDLE) && bus.valid_i && w_is_mul && !bus.flush_i) ||
       ((r_state == S_BUSY) && w_mul_hold));
`else
  assign w_is_mul       = 1'b0;
  assign w_mul_done     = 1'b0;
  assign w_mul_hold     = 1'b0;
  assign w_mul_prod     = c_zero_word[XLEN-1:0];
  assign bus.stallreq_o = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_valid_next = 1'b0;
    w_wreg_next  = 1'b0;
    w_wd_next    = r_wd;
    w_wdata_next = r_wdata;
    w_mul_start  = 1'b0;
    if (bus.flush_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_i) begin
            if (w_is_mul) begin
              w_state_next = S_BUSY;
              w_mul_start  = 1'b1;
            end else begin
              w_valid_next = 1'b1;
              w_wreg_next  = bus.wreg_i;
              w_wd_next    = bus.wd_i;
              w_wdata_next = w_alu_res;
            end
          end
        end
        S_BUSY: begin
          if (w_mul_done) begin
            w_state_next = S_IDLE;
            w_valid_next = 1'b1;
            w_wreg_next  = r_mul_wreg;
            w_wd_next    = r_mul_wd;
            w_wdata_next = w_mul_prod;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_wreg     <= 1'b0;
      r_wd       <= '0;
      r_wdata    <= '0;
      r_mul_wd   <= '0;
      r_mul_wreg <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_wreg  <= w_wreg_next;
      r_wd    <= w_wd_next;
      r_wdata <= w_wdata_next;
      if (w_mul_start) begin
        r_mul_wd   <= bus.wd_i;
        r_mul_wreg <= bus.wreg_i;
      end
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.wreg_o  = r_wreg;
  assign bus.wd_o    = r_wd;
  assign bus.wdata_o = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_ex_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_mc
// Brief  : Self-checking bench for ex_mc (directed table, random, MUL sequences).
// Rev    : 1.0
// ============================================================================
module tb_ex_mc;
  import ex_pkg::*;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mc_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

  ex_mc #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_wdata;
  logic [4:0]  last_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd, input logic wr);
    bus.valid_i  = v;
    bus.flush_i  = f;
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.wd_i     = wd;
    bus.wreg_i   = wr;
  endtask

  // Reference: each op's meaning and its required class, from the op list.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      c_aluop_or:   return (sel == c_alusel_logic) ? (a | b) : 32'd0;
      c_aluop_and:  return (sel == c_alusel_logic) ? (a & b) : 32'd0;
      c_aluop_xor:  return (sel == c_alusel_logic) ? (a ^ b) : 32'd0;
      c_aluop_nor:  return (sel == c_alusel_logic) ? ~(a | b) : 32'd0;
      c_aluop_sll:  return (sel == c_alusel_shift) ? (a << sh) : 32'd0;
      c_aluop_srl:  return (sel == c_alusel_shift) ? (a >> sh) : 32'd0;
      c_aluop_sra:  return (sel == c_alusel_shift) ? 32'($signed(a) >>> sh) : 32'd0;
      c_aluop_add:  return (sel == c_alusel_arith) ? 32'(a + b) : 32'd0;
      c_aluop_sub:  return (sel == c_alusel_arith) ? 32'(a - b) : 32'd0;
      c_aluop_slt:  return (sel == c_alusel_arith && $signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      c_aluop_sltu: return (sel == c_alusel_arith && a < b) ? 32'd1 : 32'd0;
      default:      return 32'd0;
    endcase
  endfunction

  task automatic run_single(input string name, input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                            input logic wr, input logic [31:0] exp);
    drive(1'b1, 1'b0, op, sel, a, b, wd, wr);
    #1;
    check({name, " stallreq"}, bus.stallreq_o, 1'b0);
    tick();
    bus.valid_i = 1'b0;
    check({name, " valid_o"}, bus.valid_o, 1'b1);
    check({name, " wdata_o"}, bus.wdata_o, exp);
    check({name, " wd_o"}, bus.wd_o, wd);
    check({name, " wreg_o"}, bus.wreg_o, wr);
    last_wdata = exp;
    last_wd    = wd;
  endtask

`ifdef EX_MUL_EN
  // Issues a MUL; optionally presents ADD 2+3 in the final BUSY cycle and holds it one more cycle.
  task automatic mul_seq(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr, input logic follow);
    int nstall;
    int lat;
    logic [63:0] full;
    nstall = 0;
    lat    = 0;
    full   = {32'd0, a} * {32'd0, b};
    drive(1'b1, 1'b0, c_aluop_mul, c_alusel_mul, a, b, wd, wr);
    for (int c = 0; c < 60 && lat == 0; c++) begin
      if (follow && c == XLEN) drive(1'b1, 1'b0, c_aluop_add, c_alusel_arith, 32'd2, 32'd3, 5'd9, 1'b1);
      #1;
      if (bus.stallreq_o) nstall++;
      tick();
      if (c == 0) bus.valid_i = 1'b0;
      if (bus.valid_o) lat = c + 1;
    end
    check({name, " latency"}, lat, XLEN + 1);
    check({name, " stall cycles"}, nstall, XLEN);
    check({name, " product"}, bus.wdata_o, full[31:0]);
    check({name, " wd_o"}, bus.wd_o, wd);
    check({name, " wreg_o"}, bus.wreg_o, wr);
    last_wdata = full[31:0];
    last_wd    = wd;
    if (follow) begin
      #1;
      check({name, " follow stallreq"}, bus.stallreq_o, 1'b0);
      tick();
      bus.valid_i = 1'b0;
      check({name, " follow valid_o"}, bus.valid_o, 1'b1);
      check({name, " follow wdata_o"}, bus.wdata_o, 32'd5);
      last_wdata = 32'd5;
      last_wd    = 5'd9;
    end
    tick();
    check({name, " single pulse"}, bus.valid_o, 1'b0);
  endtask
`endif

  vec_t vecs[19];
  logic [7:0] ops[11];
  logic [2:0] sels[11];

  initial begin
    vecs[0]  = '{c_aluop_or,   c_alusel_logic, 32'h0000_F0F0, 32'h0F0F_0000, 5'd3,  1'b1, 32'h0F0F_F0F0};
    vecs[1]  = '{c_aluop_and,  c_alusel_logic, 32'hFFFF_0000, 32'h1234_5678, 5'd4,  1'b1, 32'h1234_0000};
    vecs[2]  = '{c_aluop_xor,  c_alusel_logic, 32'hAAAA_5555, 32'hFFFF_0000, 5'd5,  1'b0, 32'h5555_5555};
    vecs[3]  = '{c_aluop_nor,  c_alusel_logic, 32'h0000_0000, 32'h0000_0000, 5'd6,  1'b1, 32'hFFFF_FFFF};
    vecs[4]  = '{c_aluop_nor,  c_alusel_logic, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd7,  1'b1, 32'h0000_0F0F};
    vecs[5]  = '{c_aluop_sll,  c_alusel_shift, 32'h0000_0001, 32'd31,        5'd8,  1'b1, 32'h8000_0000};
    vecs[6]  = '{c_aluop_sll,  c_alusel_shift, 32'h0000_0003, 32'h0000_0024, 5'd9,  1'b1, 32'h0000_0030};
    vecs[7]  = '{c_aluop_srl,  c_alusel_shift, 32'h8000_0000, 32'd4,         5'd10, 1'b1, 32'h0800_0000};
    vecs[8]  = '{c_aluop_sra,  c_alusel_shift, 32'h8000_0000, 32'd4,         5'd11, 1'b1, 32'hF800_0000};
    vecs[9]  = '{c_aluop_sra,  c_alusel_shift, 32'h4000_0000, 32'd4,         5'd12, 1'b0, 32'h0400_0000};
    vecs[10] = '{c_aluop_add,  c_alusel_arith, 32'hFFFF_FFFF, 32'd1,         5'd13, 1'b1, 32'h0000_0000};
    vecs[11] = '{c_aluop_sub,  c_alusel_arith, 32'h0000_0000, 32'd1,         5'd14, 1'b1, 32'hFFFF_FFFF};
    vecs[12] = '{c_aluop_slt,  c_alusel_arith, 32'hFFFF_FFFF, 32'd1,         5'd15, 1'b1, 32'h0000_0001};
    vecs[13] = '{c_aluop_slt,  c_alusel_arith, 32'h0000_0001, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'h0000_0000};
    vecs[14] = '{c_aluop_sltu, c_alusel_arith, 32'hFFFF_FFFF, 32'd1,         5'd17, 1'b1, 32'h0000_0000};
    vecs[15] = '{c_aluop_sltu, c_alusel_arith, 32'h0000_0001, 32'hFFFF_FFFF, 5'd18, 1'b1, 32'h0000_0001};
    vecs[16] = '{8'hFF,        c_alusel_logic, 32'h1234_5678, 32'h1111_1111, 5'd19, 1'b1, 32'h0000_0000};
    vecs[17] = '{c_aluop_add,  c_alusel_logic, 32'h0000_0002, 32'h0000_0003, 5'd20, 1'b1, 32'h0000_0000};
    vecs[18] = '{8'h00,        c_alusel_nop,   32'h0000_0002, 32'h0000_0003, 5'd21, 1'b1, 32'h0000_0000};

    ops  = '{c_aluop_or, c_aluop_and, c_aluop_xor, c_aluop_nor, c_aluop_sll, c_aluop_srl,
             c_aluop_sra, c_aluop_add, c_aluop_sub, c_aluop_slt, c_aluop_sltu};
    sels = '{c_alusel_logic, c_alusel_logic, c_alusel_logic, c_alusel_logic, c_alusel_shift,
             c_alusel_shift, c_alusel_shift, c_alusel_arith, c_alusel_arith, c_alusel_arith,
             c_alusel_arith};

    // Reset, with a MUL request presented to confirm stallreq_o stays low under rst.
    drive(1'b1, 1'b0, c_aluop_mul, c_alusel_mul, 32'd3, 32'd5, 5'd7, 1'b1);
    tick();
    tick();
    check("reset stallreq", bus.stallreq_o, 1'b0);
    check("reset valid_o", bus.valid_o, 1'b0);
    check("reset wreg_o", bus.wreg_o, 1'b0);
    check("reset wd_o", bus.wd_o, 5'd0);
    check("reset wdata_o", bus.wdata_o, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b,
                 vecs[i].wd, vecs[i].wreg, vecs[i].exp);
    end

    tick();
    check("idle valid_o", bus.valid_o, 1'b0);
    check("idle wdata hold", bus.wdata_o, last_wdata);

    // Flush in IDLE beats a simultaneous valid op.
    drive(1'b1, 1'b1, c_aluop_add, c_alusel_arith, 32'd7, 32'd8, 5'd30, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    check("flush idle valid_o", bus.valid_o, 1'b0);
    check("flush idle wreg_o", bus.wreg_o, 1'b0);
    check("flush idle wdata hold", bus.wdata_o, last_wdata);

    for (int i = 0; i < 300; i++) begin
      int k;
      int mode;
      logic [2:0] sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0] wd;
      logic wr;
      k    = $urandom_range(0, 10);
      mode = $urandom_range(0, 7);
      sel  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : sels[k];
      a    = $urandom;
      b    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      wd   = 5'($urandom_range(0, 31));
      wr   = 1'($urandom_range(0, 1));
      if (mode == 0) begin
        drive(1'b0, 1'b0, ops[k], sel, a, b, wd, wr);
        tick();
        check("rand idle valid_o", bus.valid_o, 1'b0);
        check("rand idle wdata hold", bus.wdata_o, last_wdata);
        check("rand idle wd hold", bus.wd_o, last_wd);
      end else if (mode == 1) begin
        drive(1'b1, 1'b1, ops[k], sel, a, b, wd, wr);
        tick();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        check("rand flush valid_o", bus.valid_o, 1'b0);
        check("rand flush wreg_o", bus.wreg_o, 1'b0);
        check("rand flush wdata hold", bus.wdata_o, last_wdata);
      end else begin
        run_single($sformatf("rand%0d", i), ops[k], sel, a, b, wd, wr, ref_alu(ops[k], sel, a, b));
      end
    end
    drive(1'b0, 1'b0, 8'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();

`ifdef EX_MUL_EN
    mul_seq("mul basic", 32'h0001_0003, 32'h0000_0005, 5'd17, 1'b1, 1'b0);
    mul_seq("mul back2back", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1);

    begin : flush_busy
      int seen;
      seen = 0;
      drive(1'b1, 1'b0, c_aluop_mul, c_alusel_mul, 32'd1234, 32'd5678, 5'd4, 1'b1);
      tick();
      bus.valid_i = 1'b0;
      repeat (9) tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      check("busy flush valid_o", bus.valid_o, 1'b0);
      check("busy flush wreg_o", bus.wreg_o, 1'b0);
      #1;
      check("busy flush stallreq", bus.stallreq_o, 1'b0);
      for (int c = 0; c < 40; c++) begin
        tick();
        if (bus.valid_o) seen++;
      end
      check("busy flush no result", seen, 0);
      run_single("after flush add", c_aluop_add, c_alusel_arith, 32'd2, 32'd3, 5'd6, 1'b1, 32'd5);
    end

    begin : reset_busy
      drive(1'b1, 1'b0, c_aluop_mul, c_alusel_mul, 32'd99, 32'd77, 5'd12, 1'b1);
      tick();
      bus.valid_i = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("busy rst stallreq", bus.stallreq_o, 1'b0);
      tick();
      rst = 1'b0;
      check("busy rst valid_o", bus.valid_o, 1'b0);
      check("busy rst wreg_o", bus.wreg_o, 1'b0);
      check("busy rst wd_o", bus.wd_o, 5'd0);
      check("busy rst wdata_o", bus.wdata_o, 32'd0);
      #1;
      check("post rst stallreq", bus.stallreq_o, 1'b0);
      mul_seq("mul after rst", 32'h0000_1234, 32'h0000_4321, 5'd13, 1'b1, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      mul_seq($sformatf("mul rand%0d", i), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
    end
`else
    begin : mul_disabled
      int seen_stall;
      seen_stall = 0;
      drive(1'b1, 1'b0, c_aluop_mul, c_alusel_mul, 32'd3, 32'd5, 5'd11, 1'b1);
      #1;
      if (bus.stallreq_o) seen_stall++;
      tick();
      bus.valid_i = 1'b0;
      check("nomul valid_o", bus.valid_o, 1'b1);
      check("nomul wdata_o", bus.wdata_o, 32'd0);
      check("nomul wd_o", bus.wd_o, 5'd11);
      check("nomul wreg_o", bus.wreg_o, 1'b1);
      #1;
      if (bus.stallreq_o) seen_stall++;
      tick();
      check("nomul single pulse", bus.valid_o, 1'b0);
      check("nomul stallreq", seen_stall, 0);
      run_single("nomul then add", c_aluop_add, c_alusel_arith, 32'd2, 32'd3, 5'd6, 1'b1, 32'd5);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
